sobel_frame_ctrl: RTL and testbench

SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

---
 rtl/sobel_frame_ctrl_if.sv | 34 +++
 rtl/sobel_frame_ctrl.sv | 114 +++++++++++
 tb/tb_sobel_frame_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_frame_ctrl_if.sv
// Handshake bundle between the Sobel frame controller, the source/result
// memories and the filter. master = controller side, slave = environment side.
interface sobel_frame_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic              abort;
  logic              hold;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              filt_clear;
  logic              filt_valid_in;
  logic [7:0]        filt_pixel_in;
  logic              filt_valid_out;
  logic [7:0]        filt_pixel_out;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    input  start, abort, hold, rd_data, filt_valid_out, filt_pixel_out,
    output busy, done, rd_en, rd_addr, filt_clear, filt_valid_in,
           filt_pixel_in, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, abort, hold, rd_data, filt_valid_out, filt_pixel_out,
    input  busy, done, rd_en, rd_addr, filt_clear, filt_valid_in,
           filt_pixel_in, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer: clears the filter, streams IMG_W*IMG_H source pixels through
// it with stall/abort support, and writes the filtered results back in order.
module sobel_frame_ctrl #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  sobel_frame_ctrl_if.master bus
);
  localparam int N     = IMG_W * IMG_H;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(N);

  typedef enum logic [2:0] {IDLE, CLEAR, READ, DRAIN, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic              rd_en_p0;
  logic [ADDR_W-1:0] rd_addr_p0;
  logic              vld_p1;
  logic              busy_q;
  logic              done_q;
  logic              clear_q;

  logic              active;
  logic              issue;
  logic              wr_fire;
  logic [CNT_W-1:0]  next_addr;

  always_comb begin
    active    = (state == READ) || (state == DRAIN);
    issue     = !bus.hold && ((state == CLEAR) || (state == READ));
    next_addr = (state == CLEAR) ? '0 : rd_cnt;
    wr_fire   = active && bus.filt_valid_out;
  end

  // The first read is issued on the edge leaving CLEAR so that the frame
  // completes N+3 edges after start is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      clear_q    <= 1'b0;
      rd_en_p0   <= 1'b0;
      rd_addr_p0 <= '0;
      vld_p1     <= 1'b0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
    end else begin
      done_q   <= 1'b0;
      clear_q  <= 1'b0;
      rd_en_p0 <= 1'b0;
      vld_p1   <= rd_en_p0;
      if (wr_fire && wr_cnt != FULL) wr_cnt <= wr_cnt + 1'b1;

      if (state != IDLE && bus.abort) begin
        state  <= IDLE;
        busy_q <= 1'b0;
        vld_p1 <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              state   <= CLEAR;
              busy_q  <= 1'b1;
              clear_q <= 1'b1;
            end
          end
          CLEAR, READ: begin
            if (state == CLEAR) begin
              rd_cnt <= '0;
              wr_cnt <= '0;
            end
            state <= READ;
            if (issue) begin
              rd_en_p0   <= 1'b1;
              rd_addr_p0 <= next_addr[ADDR_W-1:0];
              rd_cnt     <= next_addr + 1'b1;
              if (next_addr == LAST) state <= DRAIN;
            end
          end
          DRAIN: begin
            if (wr_fire && wr_cnt == LAST) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Filter stage boundary: read data lands one cycle after rd_en.
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.rd_en         = rd_en_p0;
  assign bus.rd_addr       = rd_addr_p0;
  assign bus.filt_clear    = clear_q;
  assign bus.filt_valid_in = vld_p1;
  assign bus.filt_pixel_in = bus.rd_data;
  assign bus.wr_en         = wr_fire;
  assign bus.wr_addr       = wr_cnt[ADDR_W-1:0];
  assign bus.wr_data       = active ? bus.filt_pixel_out : 8'd0;
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl on a 4x4 frame with a source memory and
// a one-cycle horizontal-gradient filter stand-in.
module tb_sobel_frame_ctrl;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 4;
  localparam int N  = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sobel_frame_ctrl_if #(.ADDR_W(AW)) bus ();

  sobel_frame_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] src [N];
  logic [7:0] prev;

  always_ff @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= src[bus.rd_addr];
  end

  // Filter stand-in: |pixel - previous pixel|, reset by rst or filt_clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || bus.filt_clear) begin
      prev               <= 8'd0;
      bus.filt_valid_out <= 1'b0;
      bus.filt_pixel_out <= 8'd0;
    end else begin
      bus.filt_valid_out <= bus.filt_valid_in;
      if (bus.filt_valid_in) begin
        bus.filt_pixel_out <= (bus.filt_pixel_in > prev) ? bus.filt_pixel_in - prev
                                                         : prev - bus.filt_pixel_in;
        prev <= bus.filt_pixel_in;
      end
    end
  end

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  logic [AW-1:0] rdq [$];
  int wa [$];
  int wd [$];
  int clr_cnt = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rd_en) rdq.push_back(bus.rd_addr);
      if (bus.wr_en) begin
        wa.push_back(int'(bus.wr_addr));
        wd.push_back(int'(bus.wr_data));
      end
      if (bus.filt_clear) clr_cnt++;
      if (bus.done) done_cnt++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_data(input int i);
    int a, b;
    a = int'(src[i]);
    b = (i == 0) ? 0 : int'(src[i-1]);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    rdq.delete();
    wa.delete();
    wd.delete();
    clr_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start(output int e0);
    e0 = edge_n + 1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int de);
    de = -1;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        de = edge_n;
        break;
      end
    end
  endtask

  task automatic wait_issue(input int addr, input int maxc, output int ok);
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (bus.rd_en === 1'b1 && int'(bus.rd_addr) == addr) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag);
    int bad;
    check({tag, "_rd_count"}, rdq.size(), N);
    bad = -1;
    foreach (rdq[i]) if (int'(rdq[i]) != i && bad < 0) bad = i;
    check({tag, "_rd_seq_bad_idx"}, bad, -1);
    check({tag, "_wr_count"}, wa.size(), N);
    bad = -1;
    foreach (wa[i]) if (wa[i] != i && bad < 0) bad = i;
    check({tag, "_wr_addr_bad_idx"}, bad, -1);
    bad = -1;
    foreach (wd[i]) if (i < N && wd[i] != exp_data(i) && bad < 0) bad = i;
    check({tag, "_wr_data_bad_idx"}, bad, -1);
    check({tag, "_clear_pulses"}, clr_cnt, 1);
    check({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    int e0, d1, d2, ok, bad;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.hold  = 1'b0;
    for (int i = 0; i < N; i++) src[i] = 8'(i);

    #2;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_filt_clear", bus.filt_clear, 0);
    check("rst_filt_valid_in", bus.filt_valid_in, 0);
    check("rst_wr_en", bus.wr_en, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // start together with abort in IDLE is ignored
    clear_log();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("idle_start_abort_busy", bus.busy, 0);
    tick();
    check("idle_start_abort_clr", clr_cnt, 0);

    // plain frame
    clear_log();
    pulse_start(e0);
    check("t1_filt_clear", bus.filt_clear, 1);
    check("t1_busy", bus.busy, 1);
    wait_done(60, d1);
    check("t1_done_edge", d1 - e0, 19);
    tick();
    check("t1_busy_after", bus.busy, 0);
    check("t1_done_after", bus.done, 0);
    check_frame("t1");

    // hold for 5 cycles after address 7
    clear_log();
    pulse_start(e0);
    wait_issue(7, 30, ok);
    check("t2_issue7_seen", ok, 1);
    bus.hold = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.hold = 1'b0;
    wait_done(60, d1);
    check("t2_done_edge", d1 - e0, 24);
    tick();
    check_frame("t2");

    // abort after address 9
    clear_log();
    pulse_start(e0);
    wait_issue(9, 30, ok);
    check("t3_issue9_seen", ok, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t3_abort_busy", bus.busy, 0);
    check("t3_abort_rd_en", bus.rd_en, 0);
    check("t3_abort_valid_in", bus.filt_valid_in, 0);
    check("t3_abort_rd_addr_held", bus.rd_addr, 9);
    repeat (10) tick();
    check("t3_reads_after_abort", rdq.size(), 10);
    check("t3_no_done", done_cnt, 0);
    clear_log();
    pulse_start(e0);
    wait_done(60, d1);
    check("t3_restart_done_edge", d1 - e0, 19);
    tick();
    check_frame("t3");

    // start held high: back-to-back frames
    clear_log();
    e0 = edge_n + 1;
    bus.start = 1'b1;
    wait_done(60, d1);
    wait_done(60, d2);
    bus.start = 1'b0;
    tick();
    tick();
    check("t4_first_done_edge", d1 - e0, 19);
    check("t4_done_spacing", d2 - d1, 21);
    check("t4_busy_after", bus.busy, 0);
    check("t4_clear_pulses", clr_cnt, 2);
    check("t4_done_pulses", done_cnt, 2);
    check("t4_rd_count", rdq.size(), 2 * N);
    check("t4_wr_count", wa.size(), 2 * N);
    bad = -1;
    foreach (wa[i]) if (wa[i] != (i % N) && bad < 0) bad = i;
    check("t4_wr_addr_bad_idx", bad, -1);
    bad = -1;
    foreach (rdq[i]) if (int'(rdq[i]) != (i % N) && bad < 0) bad = i;
    check("t4_rd_seq_bad_idx", bad, -1);

    // reset during DRAIN, then a flat frame
    clear_log();
    pulse_start(e0);
    wait_issue(15, 30, ok);
    check("t5_issue15_seen", ok, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_done", bus.done, 0);
    check("t5_rst_rd_en", bus.rd_en, 0);
    check("t5_rst_rd_addr", bus.rd_addr, 0);
    check("t5_rst_filt_clear", bus.filt_clear, 0);
    check("t5_rst_valid_in", bus.filt_valid_in, 0);
    check("t5_rst_wr_en", bus.wr_en, 0);
    check("t5_rst_wr_addr", bus.wr_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    repeat (25) tick();
    check("t5_no_done_after_rst", done_cnt, 0);
    for (int i = 0; i < N; i++) src[i] = 8'd100;
    clear_log();
    pulse_start(e0);
    wait_done(60, d1);
    check("t5_flat_done_edge", d1 - e0, 19);
    tick();
    check_frame("t5");
    bad = -1;
    foreach (wd[i]) if ((i % W) != 0 && wd[i] != 0 && bad < 0) bad = i;
    check("t5_flat_interior_bad_idx", bad, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
